// File: rtl/pulse_sequencer_pkg.sv
// Shared types and widths for the pulse sequencer: FSM states and segment-counter sizing.
package pulse_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      P1,
      D1,
      P2,
      D2,
      WAIT
   } state_t;

   localparam int SEG_W = 16;
   localparam int GAP_W = SEG_W + 1;

   // The CPMG inter-echo gap is twice the pulse-1-to-pulse-2 delay, so it needs one extra bit.
   function automatic logic [GAP_W-1:0] cpmg_gap(input logic [SEG_W-1:0] d);
      return {d, 1'b0};
   endfunction

endpackage

// File: rtl/pulse_sequencer_guard_stretch.sv
// Retriggerable stretcher: output follows the trigger and holds for GUARD extra cycles after it drops.
module guard_stretch #(
   parameter int GUARD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trig,
   output logic stretched
);

   localparam int CW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

   logic [CW-1:0] left;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left      <= '0;
         stretched <= 1'b0;
      end else if (trig) begin
         left      <= CW'(GUARD);
         stretched <= 1'b1;
      end else if (left != '0) begin
         left      <= left - CW'(1);
         stretched <= 1'b1;
      end else begin
         stretched <= 1'b0;
      end
   end

endmodule

// File: rtl/pulse_sequencer.sv
// Pulse-train generator: shadowed parameters, period counter and segment FSM driving pulse/sync/inh.
module pulse_sequencer
   import pulse_sequencer_pkg::*;
#(
   parameter int GUARD             = 4,
   parameter bit RESTART_ON_UPDATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      per,
   input  logic [SEG_W-1:0] p1wid,
   input  logic [SEG_W-1:0] del,
   input  logic [SEG_W-1:0] p2wid,
   input  logic             cp,
   input  logic             bl,
   input  logic             rxd,
   output logic             sync,
   output logic             pulse,
   output logic             inh,
   output logic [7:0]       echo_cnt,
   output logic             busy
);

   state_t           state, nxt_state;
   logic [31:0]      cnt, per_s;
   logic [SEG_W-1:0] p1wid_s, del_s, p2wid_s;
   logic             cp_s, bl_s, rxd_q;
   logic [GAP_W-1:0] rem, nxt_rem;
   logic [7:0]       nxt_echo;
   logic             run, wrap, upd, start, start_ok, load_sh;
   logic [SEG_W-1:0] w_p1, w_del, w_p2;
   logic             w_cp, w_bl;
   logic             e_d1, e_p2, e_d2, e_wait;
   logic             nxt_gate, nxt_pulse;

   assign run      = (state != IDLE);
   assign wrap     = run && (cnt == per_s - 32'd1);
   assign upd      = RESTART_ON_UPDATE && run && rxd && !rxd_q;
   assign start    = wrap || upd || (!run && (per_s >= 32'd2));
   assign start_ok = start && (per >= 32'd2);
   assign load_sh  = start || !run;

   // Next-state evaluation. On a period start the shadows load at the same edge, so the
   // incoming parameters are used directly; zero-length segments cascade within one cycle.
   always_comb begin
      w_p1      = start ? p1wid : p1wid_s;
      w_del     = start ? del   : del_s;
      w_p2      = start ? p2wid : p2wid_s;
      w_cp      = start ? cp    : cp_s;
      w_bl      = start ? bl    : bl_s;
      nxt_state = state;
      nxt_rem   = (rem != '0) ? rem - GAP_W'(1) : '0;
      nxt_echo  = echo_cnt;
      e_d1      = 1'b0;
      e_p2      = 1'b0;
      e_d2      = 1'b0;
      e_wait    = 1'b0;

      if (start) begin
         nxt_echo = '0;
         if (!start_ok) begin
            nxt_state = IDLE;
            nxt_rem   = '0;
         end else if (w_p1 != '0) begin
            nxt_state = P1;
            nxt_rem   = {1'b0, w_p1};
         end else begin
            e_d1 = 1'b1;
         end
      end else if (rem == GAP_W'(1)) begin
         case (state)
            P1:      e_d1 = 1'b1;
            D1:      e_p2 = 1'b1;
            P2: begin
               if (w_cp) e_d2 = 1'b1;
               else      e_wait = 1'b1;
            end
            D2:      e_p2 = 1'b1;
            default: ;
         endcase
      end

      if (e_d1) begin
         if (w_del != '0) begin
            nxt_state = D1;
            nxt_rem   = {1'b0, w_del};
         end else begin
            e_p2 = 1'b1;
         end
      end
      if (e_d2) begin
         if (cpmg_gap(w_del) != '0) begin
            nxt_state = D2;
            nxt_rem   = cpmg_gap(w_del);
         end else begin
            e_p2 = 1'b1;
         end
      end
      // A zero-width pulse 2 is never emitted and does not count as an echo.
      if (e_p2) begin
         if (w_p2 != '0) begin
            nxt_state = P2;
            nxt_rem   = {1'b0, w_p2};
            if (nxt_echo != 8'hFF) nxt_echo = nxt_echo + 8'd1;
         end else begin
            e_wait = 1'b1;
         end
      end
      if (e_wait) begin
         nxt_state = WAIT;
         nxt_rem   = '0;
      end

      nxt_gate  = (nxt_state == P1) || (nxt_state == P2);
      nxt_pulse = (nxt_state == P2) || ((nxt_state == P1) && w_bl);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         rem      <= '0;
         per_s    <= '0;
         p1wid_s  <= '0;
         del_s    <= '0;
         p2wid_s  <= '0;
         cp_s     <= 1'b0;
         bl_s     <= 1'b0;
         rxd_q    <= 1'b0;
         echo_cnt <= '0;
         sync     <= 1'b0;
         pulse    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         rxd_q <= rxd;
         if (load_sh) begin
            per_s   <= per;
            p1wid_s <= p1wid;
            del_s   <= del;
            p2wid_s <= p2wid;
            cp_s    <= cp;
            bl_s    <= bl;
         end
         if (start)    cnt <= '0;
         else if (run) cnt <= cnt + 32'd1;
         state    <= nxt_state;
         rem      <= nxt_rem;
         echo_cnt <= nxt_echo;
         sync     <= start_ok;
         pulse    <= nxt_pulse;
         busy     <= (nxt_state != IDLE);
      end
   end

   guard_stretch #(
      .GUARD(GUARD)
   ) u_guard (
      .clk       (clk),
      .rst_n     (rst_n),
      .trig      (nxt_gate),
      .stretched (inh)
   );

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Cycle-accurate pulse-train generator that sits directly downstream of the UART parameter-control block. It consumes the period, pulse-width, delay, CPMG and block settings that block exports, and turns them into the physical pulse, sync and receiver-inhibit lines. Parameters are shadowed at each period boundary, so a UART write never corrupts a sequence already in flight.

## Interface
- `GUARD`, default 4: receiver-inhibit extension, in cycles, after each pulse falls.
- `RESTART_ON_UPDATE`, default 1: 1 = a rising edge on `rxd` forces an immediate period restart.
- `clk`  in  1  system clock (201 MHz, 4.975 ns/cycle).
- `rst_n`  in  1  asynchronous, active-low reset.
- `per`  in  32  period in cycles.
- `p1wid`  in  16  pulse-1 width in cycles.
- `del`  in  16  pulse-1 fall to pulse-2 rise, in cycles.
- `p2wid`  in  16  pulse-2 width in cycles.
- `cp`  in  1  CPMG enable: repeat pulse 2 until the period ends.
- `bl`  in  1  1 = emit pulse 1; 0 = suppress pulse 1 (timing kept).
- `rxd`  in  1  parameter-update strobe from the control block.
- `sync`  out  1  high for the first cycle of every period.
- `pulse`  out  1  RF gate: pulse 1 OR pulse 2.
- `inh`  out  1  receiver inhibit.
- `echo_cnt`  out  8  number of pulse-2 instances emitted this period; saturates at 255.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Shadow registers hold `per`, `p1wid`, `del`, `p2wid`, `cp` and `bl`. They load on every period start and only then.
- Period counter: 32 bits, counts 0 … per_s−1, then wraps. Period start is the cycle where the counter equals 0.
- per_s < 2 means disabled:
  - FSM holds IDLE; `pulse`, `sync` and `inh` stay 0.
  - Inputs are re-sampled every cycle until `per` ≥ 2, and the first period then starts on the next cycle.
- FSM states: IDLE, P1, D1, P2, D2, WAIT.
  - Period start → P1 with a segment down-counter loaded from `p1wid`.
  - P1 → D1 → P2 when the segment counter expires. A zero-length segment is skipped in the same cycle; P1 and D1 may both be skipped.
  - After P2: if cp_s = 1, go to D2 for 2×del_s cycles (17-bit), then back to P2. If cp_s = 0, go to WAIT.
  - Period wrap from any state aborts the sequence and re-enters P1, with shadows reloaded. Truncation on overrun is deliberate.
- `echo_cnt` clears at period start and increments on each P2 entry; it saturates at 255.
- `inh` is high whenever `pulse` is high, and for `GUARD` cycles after `pulse` falls. A new pulse during the guard window re-arms it.
- bl_s = 0 masks `pulse` in P1 only; P1 duration and `inh` are unchanged.
- `rxd` rising edge with RESTART_ON_UPDATE = 1: the next cycle is a forced period start, the counter goes to 0 and shadows reload. With RESTART_ON_UPDATE = 0, `rxd` is ignored.
- If an `rxd` edge coincides with a natural wrap, exactly one period start occurs.

## Timing
- Reset values: counter 0, state IDLE, shadows 0, `sync`, `pulse`, `inh` and `busy` 0, `echo_cnt` 0.
- After `rst_n` deasserts:
  - cycle 1 samples inputs;
  - cycle 2 is the first period start (`sync` = 1), provided `per` ≥ 2.
- All outputs are registered.
- `pulse` rises in the same cycle as `sync`, and is high for exactly p1wid_s cycles.
- Pulse-2 rise = period start + p1wid_s + del_s cycles; it is high for p2wid_s cycles.
- CPMG pulse-2 rise-to-rise spacing is p2wid_s + 2×del_s.
- Reset asserted mid-sequence clears all outputs asynchronously within the same cycle.

## Structure
- Shared package holds the state enum, the segment-counter width constant (16) and the 17-bit CPMG gap width.
- The natural sub-module is `guard_stretch`, a retriggerable pulse stretcher for `inh`.
- The FSM, period counter and shadows stay in the top module.

## Test plan
- per = 100, p1wid = 5, del = 10, p2wid = 8, cp = 0, bl = 1. Expect:
  - `sync` every 100 cycles;
  - `pulse` high on cycles 0–4 and 15–22;
  - `echo_cnt` = 1;
  - `inh` falls at cycle 27.
- Same settings with cp = 1, per = 200. Pulse-2 rises at 15, 43, 71, … 183; `echo_cnt` = 7.
- Same settings with bl = 0. `pulse` is low on cycles 0–4, pulse 2 is unchanged, and `inh` is still high on cycles 0–4.
- Overrun: per = 20, p1wid = 30. `pulse` is high for all 20 cycles, and `sync` repeats every 20 cycles with no gap.
- Mid-period update: change `del` to 3 and pulse `rxd` at cycle 50. A restart occurs at cycle 51, and pulse 2 rises at cycle 59.
- Zero-length segments: p1wid = 0 and del = 0. Pulse 2 rises at the period-start cycle. Separately, per = 1 keeps all outputs at 0.
